uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Serial 8N1 UART receiver with a small output FIFO; the receive-side counterpart to the SoC's TXD output.
- Two uses:
  - Inside the SoC as the RXD input path.
  - In the testbench, connected to soc TXD, to decode and check CPU console output.
- Serial line is oversampled with the system clock.
- Received bytes are queued and presented on a valid/ready interface.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200). Legal range ≥ 4.
- FIFO_DEPTH, 4, byte slots in the output FIFO. Power of 2, ≥ 2.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- RXD  in  1  asynchronous serial input; idle high.
- RX_DATA  out  8  byte at FIFO head; valid only while RX_VALID = 1.
- RX_VALID  out  1  FIFO non-empty.
- RX_READY  in  1  consumer accepts head when RX_VALID & RX_READY.
- FRAME_ERR  out  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  out  1  one-cycle pulse: good byte dropped because FIFO full.
- BUSY  out  1  high whenever FSM is not IDLE.

Behaviour:
- Interface: one clock, CLK. Reset is synchronous, active-high on RESET.
- Reset state:
  - 2-flop RXD synchronizer preset to 1.
  - FSM = IDLE; bit counter and cycle counter = 0.
  - FIFO empty.
  - RX_VALID, FRAME_ERR, OVERRUN, BUSY = 0. RX_DATA = 0.
- RESET mid-frame aborts the frame and discards FIFO contents.
- All FSM decisions use the synchronized RXD (rxs). Let t0 be the first cycle rxs = 0 while in IDLE.
- FSM states and transitions:
  - IDLE: on rxs = 0 → START; cycle counter cleared.
  - START: at t0 + CLKS_PER_BIT/2 (integer division), sample rxs.
    - rxs = 0 → DATA.
    - rxs = 1 → glitch; return to IDLE with no output.
  - DATA: bit i (i = 0..7, LSB first) sampled at t0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT, shifted into the data register. After bit 7 → STOP.
  - STOP: stop bit sampled at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
    - rxs = 1, FIFO not full (or a pop occurs in that cycle): push the byte → IDLE.
    - rxs = 1, FIFO full with no pop: drop the byte, pulse OVERRUN → IDLE.
    - rxs = 0: pulse FRAME_ERR, discard the byte → BREAK.
  - BREAK: wait until rxs = 1, then → IDLE. A falling edge is not a start bit until the line has been high for at least one cycle.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately after the stop bit is detected. No idle gap is required.
- Latency:
  - Pushed byte appears on RX_DATA with RX_VALID = 1 on the cycle after the stop-sample cycle.
  - FRAME_ERR and OVERRUN assert on that same following cycle, for exactly 1 cycle.
- FIFO:
  - First-word-fall-through; RX_DATA always shows the head.
  - Pop when RX_VALID & RX_READY; the next entry is visible on the following cycle.
  - Read/write pointers wrap modulo FIFO_DEPTH. Occupancy count is 0..FIFO_DEPTH.
  - Simultaneous push and pop:
    - When full: both occur, count unchanged, no OVERRUN.
    - When empty: push only (pop is impossible since RX_VALID = 0).
  - RX_READY while RX_VALID = 0 is ignored.
- Counters: cycle counter width is $clog2(CLKS_PER_BIT). It is reset at every sample point and saturates nowhere.

Test Plan (CLKS_PER_BIT = 8, FIFO_DEPTH = 4, RX_READY = 1 unless stated):
1. Send 0x55 with a valid stop bit → RX_VALID pulses 1 cycle, RX_DATA = 0x55, FRAME_ERR = 0, OVERRUN = 0. Timing is checked against the stop-sample cycle.
2. Drive RXD low for 3 cycles, then high → START rejects the glitch, BUSY returns to 0, no byte pushed. A following frame 0xC3 is received correctly.
3. Send 0xA5 with stop bit = 0, hold RXD low 20 cycles, release, then send 0x3C → one FRAME_ERR pulse, 0xA5 not pushed, only 0x3C output.
4. RX_READY = 0; send 0x01..0x05 → RX_VALID held, FIFO full after 0x04, one OVERRUN pulse on 0x05. Raising RX_READY drains exactly 0x01, 0x02, 0x03, 0x04.
5. With the FIFO full, send a byte whose push cycle coincides with a pop → no OVERRUN, count stays 4, new byte is last out.
6. Send 0x00 then 0xFF back-to-back with no idle gap → both received in order. Then assert RESET during bit 3 of a frame → FIFO empty, all outputs 0; next frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver, oversampled by the system clock, with a small
// first-word-fall-through FIFO presenting received bytes on valid/ready.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BUSY
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } state_t;

    logic          sync1_r;
    logic          rxs_r;
    state_t        state_r;
    state_t        state_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic [2:0]    bit_r;
    logic [2:0]    bit_n;
    logic [7:0]    shift_r;
    logic [7:0]    shift_n;
    logic          push_req_s;
    logic          ferr_s;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          ferr_r;
    logic          ovr_r;
    logic          busy_r;

    logic          valid_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          ovr_s;

    // Receiver next-state: all timing is counted from the synchronized line.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r + CW'(1);
        bit_n      = bit_r;
        shift_n    = shift_r;
        push_req_s = 1'b0;
        ferr_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rxs_r) begin
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_n = '0;
                    bit_n = 3'd0;
                    if (rxs_r) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_n   = '0;
                    shift_n = {rxs_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_n = ST_STOP;
                    end else begin
                        bit_n = bit_r + 3'd1;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit lets a start bit follow with no gap.
                if (cnt_r == FULL_M1) begin
                    cnt_n = '0;
                    if (rxs_r) begin
                        push_req_s = 1'b1;
                        state_n    = ST_IDLE;
                    end else begin
                        ferr_s  = 1'b1;
                        state_n = ST_BRK;
                    end
                end else begin
                    state_n = ST_STOP;
                end
            end
            ST_BRK: begin
                cnt_n = '0;
                if (rxs_r) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_BRK;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // A pop frees the slot the push needs, so full-with-pop still accepts.
    always_comb begin
        valid_s = (count_r != '0);
        full_s  = (count_r == DEPTH_C);
        pop_s   = valid_s & RX_READY;
        push_s  = push_req_s & (~full_s | pop_s);
        ovr_s   = push_req_s & full_s & ~pop_s;
    end

    // Synchronizer, receiver state and status pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            sync1_r <= RXD;
            rxs_r   <= sync1_r;
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            ferr_r  <= ferr_s;
            ovr_r   <= ovr_s;
            busy_r  <= (state_n != ST_IDLE);
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign RX_DATA   = mem_r[rd_ptr_r];
    assign RX_VALID  = valid_s;
    assign FRAME_ERR = ferr_r;
    assign OVERRUN   = ovr_r;
    assign BUSY      = busy_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scenario bench for uart_rx_fifo: serial frames are driven, expected bytes
// queued at stimulus time and compared against bytes accepted from the FIFO.
module tb_uart_rx_fifo;

    localparam int C = 8;
    localparam int D = 4;
    localparam int STOP_LAT = C / 2 + 9 * C + 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RXD = 1'b1;
    logic       RX_READY = 1'b1;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;

    int n_checks = 0;
    int n_fail = 0;
    int cycle_cnt = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];

    uart_rx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RESET(RESET), .RXD(RXD), .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID), .RX_READY(RX_READY), .FRAME_ERR(FRAME_ERR),
        .OVERRUN(OVERRUN), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle_cnt <= cycle_cnt + 1;

    // Collects accepted bytes and pulse counts on the falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (RX_VALID && RX_READY) begin
                    got_q.push_back(RX_DATA);
                    got_cyc_q.push_back(cycle_cnt);
                end
                if (RX_VALID) valid_cycles++;
                if (FRAME_ERR) ferr_cnt++;
                if (OVERRUN) ovr_cnt++;
            end
        end
    end

    task automatic hold(input logic v, input int n);
        RXD = v;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        hold(1'b0, C);
        for (int i = 0; i < 8; i++) hold(b[i], C);
        hold(stop, C);
    endtask

    task automatic wait_got(input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        RXD = 1'b1;
        RX_READY = 1'b1;
        repeat (3) begin @(posedge CLK); #1; end
        n_checks++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", RX_VALID); end
        n_checks++; if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", RX_DATA); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        n_checks++; if (FRAME_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", FRAME_ERR); end
        n_checks++; if (OVERRUN !== 1'b0) begin n_fail++; $display("FAIL reset_ovr got=%b exp=0", OVERRUN); end
        RESET = 1'b0;
        hold(1'b1, 4);
    endtask

    task automatic test_single;
        int start_cyc, v0, f0, o0, gc;
        logic [7:0] e, g;
        start_cyc = cycle_cnt;
        v0 = valid_cycles; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        wait_got(1, 50);
        hold(1'b1, 4);
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); gc = got_cyc_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL single_data got=%h exp=%h", g, e); end
            n_checks++; if (gc !== start_cyc + STOP_LAT) begin n_fail++; $display("FAIL single_latency got=%0d exp=%0d", gc - start_cyc, STOP_LAT); end
        end
        n_checks++; if (valid_cycles - v0 !== 1) begin n_fail++; $display("FAIL single_valid_width got=%0d exp=1", valid_cycles - v0); end
        n_checks++; if (ferr_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_ferr got=%0d exp=0", ferr_cnt - f0); end
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL single_ovr got=%0d exp=0", ovr_cnt - o0); end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_glitch;
        logic [7:0] e, g;
        hold(1'b0, 3);
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got=%b exp=1", BUSY); end
        hold(1'b1, 12);
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle got=%b exp=0", BUSY); end
        n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL glitch_no_byte got=%0d exp=0", got_q.size()); end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_got(1, 50);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL glitch_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL glitch_data got=%h exp=%h", g, e); end
        end
        hold(1'b1, 4);
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_frame_error;
        int f0;
        logic [7:0] e, g;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b0);
        hold(1'b0, 20);
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_break got=%b exp=1", BUSY); end
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_pulse got=%0d exp=1", ferr_cnt - f0); end
        n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL ferr_dropped got=%0d exp=0", got_q.size()); end
        hold(1'b1, 4);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        wait_got(1, 50);
        hold(1'b1, 4);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ferr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL ferr_data got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_overrun;
        int o0, model_cnt, exp_ovr;
        logic [7:0] e, g;
        o0 = ovr_cnt; model_cnt = 0; exp_ovr = 0;
        RX_READY = 1'b0;
        for (int b = 1; b <= 5; b++) begin
            if (model_cnt < D) begin
                exp_q.push_back(8'(b));
                model_cnt++;
            end else begin
                exp_ovr++;
            end
            send_frame(8'(b), 1'b1);
            hold(1'b1, 2);
            if (b == 4) begin
                n_checks++; if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held got=%b exp=1", RX_VALID); end
                n_checks++; if (RX_DATA !== 8'h01) begin n_fail++; $display("FAIL ovr_head got=%h exp=01", RX_DATA); end
            end
        end
        n_checks++; if (ovr_cnt - o0 !== exp_ovr) begin n_fail++; $display("FAIL ovr_pulse got=%0d exp=%0d", ovr_cnt - o0, exp_ovr); end
        RX_READY = 1'b1;
        wait_got(D, 100);
        hold(1'b1, 4);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovr_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL ovr_data got=%h exp=%h", g, e); end
        end
        n_checks++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL ovr_drained got=%b exp=0", RX_VALID); end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_full_push_pop;
        int o0;
        logic [7:0] e, g;
        RX_READY = 1'b0;
        for (int b = 0; b < D; b++) begin
            exp_q.push_back(8'h10 + 8'(b));
            send_frame(8'h10 + 8'(b), 1'b1);
            hold(1'b1, 2);
        end
        o0 = ovr_cnt;
        exp_q.push_back(8'h99);
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (STOP_LAT - 1) @(posedge CLK);
                #1 RX_READY = 1'b1;
                @(posedge CLK);
                #1 RX_READY = 1'b0;
            end
        join
        hold(1'b1, 2);
        n_checks++; if (ovr_cnt - o0 !== 0) begin n_fail++; $display("FAIL fullpp_ovr got=%0d exp=0", ovr_cnt - o0); end
        n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL fullpp_one_pop got=%0d exp=1", got_q.size()); end
        RX_READY = 1'b1;
        wait_got(D + 1, 100);
        hold(1'b1, 4);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fullpp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL fullpp_data got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, g;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_got(2, 50);
        hold(1'b1, 4);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    task automatic test_mid_reset;
        logic [7:0] e, g;
        RX_READY = 1'b0;
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 2);
        n_checks++; if (RX_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid got=%b exp=1", RX_VALID); end
        hold(1'b0, 4 * C + C / 2);
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got=%b exp=1", BUSY); end
        RXD = 1'b1;
        RESET = 1'b1;
        repeat (2) begin @(posedge CLK); #1; end
        n_checks++; if (RX_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", RX_VALID); end
        n_checks++; if (RX_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_data got=%h exp=00", RX_DATA); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
        n_checks++; if ({FRAME_ERR, OVERRUN} !== 2'b00) begin n_fail++; $display("FAIL rst_pulses got=%b exp=00", {FRAME_ERR, OVERRUN}); end
        RESET = 1'b0;
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
        hold(1'b1, 4);
        RX_READY = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        wait_got(1, 50);
        hold(1'b1, 4);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rst_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL rst_data_after got=%h exp=%h", g, e); end
        end
        exp_q.delete(); got_q.delete(); got_cyc_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_push_pop();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
